// File: rtl/sos_sample_feeder_if.sv
// Source-sample stream (valid/ready/data) feeding sos_sample_feeder.
interface sos_sample_feeder_if #(
  parameter int unsigned W = 16
) ();
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sos_sample_feeder.sv
// Input stage of the SOS cascade: FIFO, Q1.15 -> Q2.10 round/saturate, one x update every DIV clocks.
// Define SOS_FEED_HOLD_EN to make an empty-FIFO tick hold the previous x instead of forcing 0.
module sos_sample_feeder #(
  parameter int unsigned WI_S   = 1,
  parameter int unsigned WF_S   = 15,
  parameter int unsigned WI_OUT = 2,
  parameter int unsigned WF_OUT = 10,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DIV    = 4
) (
  input  logic                         CLK,
  input  logic                         rst,
  sos_sample_feeder_if.slave           s,
  output logic [WI_OUT+WF_OUT-1:0]     x,
  output logic                         x_strobe,
  output logic                         underrun,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int unsigned WS     = WI_S + WF_S;
  localparam int unsigned WO     = WI_OUT + WF_OUT;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = $clog2(DIV);
  localparam int unsigned SH     = WF_S - WF_OUT;
  localparam int unsigned WW     = (((WS + 1) > WO) ? (WS + 1) : WO) + 1;
  localparam int unsigned RND_SH = (SH > 0) ? (SH - 1) : 0;

  localparam logic [WW-1:0]        RND   = (SH > 0) ? (WW'(1) << RND_SH) : '0;
  localparam logic signed [WW-1:0] MAX_V = $signed((WW'(1) << (WO - 1)) - WW'(1));
  localparam logic signed [WW-1:0] MIN_V = -MAX_V - WW'(1);

  logic [WS-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WO-1:0]   x_q, x_d;
  logic            strobe_q, strobe_d;
  logic            underrun_q, underrun_d;
  logic            ready_q, ready_d;

  logic            tick, empty, push, pop;
  logic [WS-1:0]   head;
  logic signed [WW-1:0] ext, sum, t;
  logic [WO-1:0]   conv;

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign empty = (level_q == '0);
  assign push  = s.s_valid & ready_q;
  assign pop   = tick & ~empty;
  assign head  = mem_q[rd_ptr_q];

  // Widened intermediate keeps the rounding add from wrapping near full scale.
  always_comb begin
    ext = {{(WW - WS){head[WS-1]}}, head};
    sum = ext + $signed(RND);
    t   = sum >>> SH;
    if (t > MAX_V) begin
      conv = MAX_V[WO-1:0];
    end else if (t < MIN_V) begin
      conv = MIN_V[WO-1:0];
    end else begin
      conv = t[WO-1:0];
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    ready_d    = (level_d != (AW + 1)'(DEPTH));
    cnt_d      = tick ? '0 : cnt_q + CW'(1);
    strobe_d   = tick;
    underrun_d = underrun_q | (tick & empty);
    x_d        = x_q;
    if (pop) begin
      x_d = conv;
    end else if (tick) begin
`ifdef SOS_FEED_HOLD_EN
      x_d = x_q;
`else
      x_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
      x_q        <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s.s_data;
    end
  end

  assign s.s_ready = ready_q;
  assign x         = x_q;
  assign x_strobe  = strobe_q;
  assign underrun  = underrun_q;
  assign level     = level_q;

endmodule

// File: tb/tb_sos_sample_feeder.sv
// Self-checking bench for sos_sample_feeder: scoreboard queue of converted samples vs. x_strobe output.
module tb_sos_sample_feeder;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] x;
  logic        x_strobe;
  logic        underrun;
  logic [3:0]  level;

  sos_sample_feeder_if #(.W(16)) sif ();

  sos_sample_feeder dut (
    .CLK      (CLK),
    .rst      (rst),
    .s        (sif),
    .x        (x),
    .x_strobe (x_strobe),
    .underrun (underrun),
    .level    (level)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          max_level = 0;
  logic [11:0] q[$];
  logic [15:0] pend_q[$];
  logic [11:0] last_x = '0;
  bit          und_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] conv(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    v = (v + 16) >>> 5;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return v[11:0];
  endfunction

  always @(posedge CLK or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(posedge CLK) begin
    if (rst && sif.s_valid && sif.s_ready) pend_q.push_back(sif.s_data);
  end

  always @(negedge CLK) begin
    logic [11:0] exp_x;
    if (rst && cyc > 0) begin
      check("x_strobe", 32'(x_strobe), 32'((cyc % DIV) == 0));
      if (x_strobe) begin
        if (q.size() > 0) begin
          exp_x = q.pop_front();
        end else begin
          und_m = 1'b1;
`ifdef SOS_FEED_HOLD_EN
          exp_x = last_x;
`else
          exp_x = '0;
`endif
        end
        last_x = exp_x;
        check("x", 32'(x), 32'(exp_x));
      end
      while (pend_q.size() > 0) q.push_back(conv(pend_q.pop_front()));
      check("level", 32'(level), 32'(q.size()));
      check("s_ready", 32'(sif.s_ready), 32'(q.size() != DEPTH));
      check("underrun", 32'(underrun), 32'(und_m));
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    int n = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    while (!sif.s_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL push_timeout: observed s_ready 0 expected 1");
    end
    step();
  endtask

  task automatic drain();
    int n = 0;
    sif.s_valid = 1'b0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: observed level %0d expected 0", q.size());
    end
    repeat (2) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    repeat (2) step();
    check("rst_x", 32'(x), 32'h0);
    check("rst_strobe", 32'(x_strobe), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_ready", 32'(sif.s_ready), 32'h0);
    rst = 1'b1;

    // Idle: ticks at clocks 4, 8, 12 with an empty FIFO.
    repeat (13) step();
    check("idle_underrun", 32'(underrun), 32'h1);
    check("idle_ready", 32'(sif.s_ready), 32'h1);

    push(16'h4000);
    drain();
    check("t2_last", 32'(last_x), 32'h200);
    push(16'hC000);
    drain();
    check("t2_last_neg", 32'(last_x), 32'hE00);
    check("t2_level", 32'(level), 32'h0);

    push(16'h0010);
    push(16'h000F);
    push(16'h7FFF);
    push(16'h8000);
    push(16'hFFEF);
    drain();
    check("t3_last", 32'(last_x), 32'hFFF);

    for (int i = 1; i <= 20; i++) push(16'(i << 5));
    drain();
    check("t4_max_level", 32'(max_level), 32'(DEPTH));
    check("t4_last", 32'(last_x), 32'd20);

    // Push on the same edge as a tick with the FIFO empty.
    n = 0;
    while ((cyc % DIV) != DIV - 1 && n < 8) begin
      step();
      n++;
    end
    sif.s_valid = 1'b1;
    sif.s_data  = 16'h0060;
    step();
    sif.s_valid = 1'b0;
    check("t5_x", 32'(x), 32'h0);
    check("t5_strobe", 32'(x_strobe), 32'h1);
    check("t5_level", 32'(level), 32'h1);
    drain();
    check("t5_last", 32'(last_x), 32'h3);

    // Mid-stream asynchronous reset with five words queued.
    n = 7;
    while (q.size() < 5 && n < 40) begin
      push(16'(n << 5));
      n++;
    end
    sif.s_valid = 1'b0;
    check("t6_level_pre", 32'(level), 32'h5);
    #2;
    rst = 1'b0;
    q.delete();
    pend_q.delete();
    und_m  = 1'b0;
    last_x = '0;
    #1;
    check("t6_x", 32'(x), 32'h0);
    check("t6_strobe", 32'(x_strobe), 32'h0);
    check("t6_level", 32'(level), 32'h0);
    check("t6_ready", 32'(sif.s_ready), 32'h0);
    check("t6_underrun", 32'(underrun), 32'h0);
    repeat (2) step();
    rst = 1'b1;
    repeat (10) step();
    check("t6_post_underrun", 32'(underrun), 32'h1);
    check("t6_post_level", 32'(level), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
